fmul_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754 binary floating-point multiplier. It succeeds the fixed 3-stage fp32 multiplier. New in this block: configurable exponent/mantissa widths, four rounding modes, full special-value handling (NaN/Inf/zero), exception flags, valid/ready backpressure, and a tag passthrough. It sits in the FPU execute path behind the issue logic and feeds the FPU writeback mux.

---
 rtl/fpu_pkg.sv | 44 ++++
 rtl/fmul_round.sv | 84 ++++++++
 rtl/fmul_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_fmul_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exception flag layout, operand classes
// and format constants derived from the exponent/mantissa widths.
package fpu_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } rm_e;

    localparam int FLG_NX = 0;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_NV = 3;

    // Field order matches the flags port: {invalid, overflow, underflow, inexact}.
    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } flags_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } cls_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fmul_round.sv
// Normalise, round and range-check a raw significand product. Purely combinational,
// written so the adder and divider can drive it with their own wide significands.
module fmul_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   i_sign,
    input  logic [EXP_W+1:0]       i_exp,
    input  logic [2*MAN_W+1:0]     i_prod,
    input  rm_e                    i_rm,
    output logic [EXP_W+MAN_W:0]   o_y,
    output flags_t                 o_flags
);

    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic               w_top;
    logic [PW-2:0]      w_norm;
    logic [MAN_W-1:0]   w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inexact;
    logic               w_inc;
    logic [XW-1:0]      w_exp_n;
    logic [MAN_W:0]     w_mant_r;
    logic [XW-1:0]      w_exp_r;
    logic               w_under;
    logic               w_over;
    logic               w_to_inf;

    // Product of two [1,2) significands lies in [1,4); a set top bit means one extra exponent step.
    assign w_top    = i_prod[PW-1];
    assign w_norm   = w_top ? i_prod[PW-2:0] : {i_prod[PW-3:0], 1'b0};
    assign w_frac   = w_norm[PW-2 -: MAN_W];
    assign w_guard  = w_norm[MAN_W];
    assign w_sticky = |w_norm[MAN_W-1:0];
    assign w_inexact = w_guard | w_sticky;
    assign w_exp_n  = i_exp + {{(XW-1){1'b0}}, w_top};

    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RNE:  w_inc = w_guard & (w_sticky | w_frac[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = w_inexact & i_sign;
            RM_RUP:  w_inc = w_inexact & ~i_sign;
            default: w_inc = 1'b0;
        endcase
    end

    // A carry out of the fraction leaves it all zeros, so only the exponent needs the +1.
    assign w_mant_r = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
    assign w_exp_r  = w_exp_n + {{(XW-1){1'b0}}, w_mant_r[MAN_W]};

    assign w_under  = $signed(w_exp_n) <= 0;
    assign w_over   = $signed(w_exp_r) >= $signed(EXP_MAX);
    assign w_to_inf = (i_rm == RM_RNE) |
                      ((i_rm == RM_RUP) & ~i_sign) |
                      ((i_rm == RM_RDN) & i_sign);

    always_comb begin
        o_y     = {i_sign, w_exp_r[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
        o_flags = '0;
        o_flags.nx = w_inexact;
        if (w_under) begin
            o_y        = {i_sign, {(EXP_W+MAN_W){1'b0}}};
            o_flags.uf = 1'b1;
            o_flags.nx = 1'b1;
        end else if (w_over) begin
            o_flags.of = 1'b1;
            o_flags.nx = 1'b1;
            if (w_to_inf) begin
                o_y = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                o_y = {i_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage IEEE-754 multiplier: S1 unpack/classify, S2 sign/exponent/significand
// product plus special-value resolution, S3 normalise/round into the output register.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    input  logic [1:0]             rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic [3:0]             flags,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS = XW'(fp_bias(EXP_W));
    localparam logic [W-1:0]  QNAN = W'(fp_qnan(EXP_W, MAN_W));

    function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '1) begin
            if (f == '0) return CLS_INF;
            return f[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
        end
        // Subnormals are flushed here by classing them as zero.
        if (e == '0) return CLS_ZERO;
        return CLS_NORM;
    endfunction

    // Valid/ready: an input is taken on in_valid & in_ready, a result leaves on
    // out_valid & out_ready; when the output is held the whole pipe freezes, bubbles included.
    logic               w_stall;

    logic               r1_valid;
    logic               r1_sgn1, r1_sgn2;
    logic [EXP_W-1:0]   r1_exp1, r1_exp2;
    logic [SW-1:0]      r1_sig1, r1_sig2;
    cls_e               r1_cls1, r1_cls2;
    rm_e                r1_rm;
    logic [TAG_W-1:0]   r1_tag;

    logic               r2_valid;
    logic               r2_sign;
    logic [XW-1:0]      r2_exp;
    logic [PW-1:0]      r2_prod;
    logic               r2_spec;
    logic [W-1:0]       r2_spec_y;
    logic               r2_spec_nv;
    rm_e                r2_rm;
    logic [TAG_W-1:0]   r2_tag;

    logic               r3_valid;
    logic [W-1:0]       r3_y;
    flags_t             r3_flags;
    logic [TAG_W-1:0]   r3_tag;

    assign w_stall  = r3_valid & ~out_ready;
    assign in_ready = ~w_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1_valid <= 1'b0;
            r1_sgn1  <= 1'b0;
            r1_sgn2  <= 1'b0;
            r1_exp1  <= '0;
            r1_exp2  <= '0;
            r1_sig1  <= '0;
            r1_sig2  <= '0;
            r1_cls1  <= CLS_ZERO;
            r1_cls2  <= CLS_ZERO;
            r1_rm    <= RM_RNE;
            r1_tag   <= '0;
        end else if (!w_stall) begin
            r1_valid <= in_valid;
            r1_sgn1  <= x1[W-1];
            r1_sgn2  <= x2[W-1];
            r1_exp1  <= x1[W-2 -: EXP_W];
            r1_exp2  <= x2[W-2 -: EXP_W];
            r1_sig1  <= {1'b1, x1[MAN_W-1:0]};
            r1_sig2  <= {1'b1, x2[MAN_W-1:0]};
            r1_cls1  <= classify(x1[W-2 -: EXP_W], x1[MAN_W-1:0]);
            r1_cls2  <= classify(x2[W-2 -: EXP_W], x2[MAN_W-1:0]);
            r1_rm    <= rm_e'(rm);
            r1_tag   <= in_tag;
        end
    end

    logic               w_sign;
    logic [XW-1:0]      w_exp_sum;
    logic [PW-1:0]      w_prod;
    logic               w_nan_in;
    logic               w_snan_in;
    logic               w_inf_in;
    logic               w_zero_in;
    logic               w_inf_zero;
    logic               w_is_spec;
    logic [W-1:0]       w_spec_y;
    logic               w_spec_nv;

    assign w_sign    = r1_sgn1 ^ r1_sgn2;
    assign w_exp_sum = {2'b00, r1_exp1} + {2'b00, r1_exp2} - BIAS;
    assign w_prod    = PW'(r1_sig1) * PW'(r1_sig2);

    assign w_nan_in   = (r1_cls1 == CLS_QNAN) | (r1_cls1 == CLS_SNAN) |
                        (r1_cls2 == CLS_QNAN) | (r1_cls2 == CLS_SNAN);
    assign w_snan_in  = (r1_cls1 == CLS_SNAN) | (r1_cls2 == CLS_SNAN);
    assign w_inf_in   = (r1_cls1 == CLS_INF) | (r1_cls2 == CLS_INF);
    assign w_zero_in  = (r1_cls1 == CLS_ZERO) | (r1_cls2 == CLS_ZERO);
    assign w_inf_zero = ((r1_cls1 == CLS_INF) & (r1_cls2 == CLS_ZERO)) |
                        ((r1_cls2 == CLS_INF) & (r1_cls1 == CLS_ZERO));

    // Priority: NaN or Inf*0, then Inf, then zero; only finite nonzero pairs reach the rounder.
    always_comb begin
        w_is_spec = 1'b0;
        w_spec_y  = '0;
        w_spec_nv = 1'b0;
        if (w_nan_in | w_inf_zero) begin
            w_is_spec = 1'b1;
            w_spec_y  = QNAN;
            w_spec_nv = w_inf_zero | w_snan_in;
        end else if (w_inf_in) begin
            w_is_spec = 1'b1;
            w_spec_y  = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_zero_in) begin
            w_is_spec = 1'b1;
            w_spec_y  = {w_sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r2_valid   <= 1'b0;
            r2_sign    <= 1'b0;
            r2_exp     <= '0;
            r2_prod    <= '0;
            r2_spec    <= 1'b0;
            r2_spec_y  <= '0;
            r2_spec_nv <= 1'b0;
            r2_rm      <= RM_RNE;
            r2_tag     <= '0;
        end else if (!w_stall) begin
            r2_valid   <= r1_valid;
            r2_sign    <= w_sign;
            r2_exp     <= w_exp_sum;
            r2_prod    <= w_prod;
            r2_spec    <= w_is_spec;
            r2_spec_y  <= w_spec_y;
            r2_spec_nv <= w_spec_nv;
            r2_rm      <= r1_rm;
            r2_tag     <= r1_tag;
        end
    end

    logic [W-1:0]       w_rnd_y;
    flags_t             w_rnd_flags;
    logic [W-1:0]       w_res_y;
    flags_t             w_res_flags;

    fmul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_sign  (r2_sign),
        .i_exp   (r2_exp),
        .i_prod  (r2_prod),
        .i_rm    (r2_rm),
        .o_y     (w_rnd_y),
        .o_flags (w_rnd_flags)
    );

    always_comb begin
        w_res_y     = w_rnd_y;
        w_res_flags = w_rnd_flags;
        if (r2_spec) begin
            w_res_y        = r2_spec_y;
            w_res_flags    = '0;
            w_res_flags.nv = r2_spec_nv;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r3_valid <= 1'b0;
            r3_y     <= '0;
            r3_flags <= '0;
            r3_tag   <= '0;
        end else if (!w_stall) begin
            r3_valid <= r2_valid;
            r3_y     <= w_res_y;
            r3_flags <= w_res_flags;
            r3_tag   <= r2_tag;
        end
    end

    assign out_valid = r3_valid;
    assign y         = r3_y;
    assign flags     = r3_flags;
    assign out_tag   = r3_tag;

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe (fp32): directed vectors, randomized traffic against an
// exact-arithmetic reference, backpressure and mid-flight reset.
module tb_fmul_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 5;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = W + 4 + TAG_W;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [1:0]       rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     y;
    logic [3:0]       flags;
    logic [TAG_W-1:0] out_tag;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    bit            lat_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    fmul_pipe #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .rm        (rm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    // ---------------- clock / ready driver ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Exact product p = ma*mb, keep the top 24 bits, round by comparing the
    // discarded remainder against one half ulp.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m);
        bit s, an, bn, asn, bsn, ai, bi, az, bz, up, nx;
        longint unsigned p, q, rem, half;
        int k, eb;
        logic [31:0] inf_v, max_v, r;
        s   = a[31] ^ b[31];
        an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        asn = an && !a[22];
        bsn = bn && !b[22];
        ai  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        az  = (a[30:23] == 8'h00);
        bz  = (b[30:23] == 8'h00);
        if (an || bn || (ai && bz) || (bi && az))
            return {32'h7FC00000, (asn || bsn || (ai && bz) || (bi && az)) ? 4'b1000 : 4'b0000};
        if (ai || bi) return {s, 8'hFF, 23'd0, 4'b0000};
        if (az || bz) return {s, 31'd0, 4'b0000};
        p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        k = 0;
        while ((p >> k) >= 64'd16777216) k++;
        eb = int'({24'd0, a[30:23]}) + int'({24'd0, b[30:23]}) - 127 + k - 23;
        if (eb <= 0) return {s, 31'd0, 4'b0011};
        q    = p >> k;
        rem  = p - (q << k);
        half = 64'd1 << (k - 1);
        nx   = (rem != 0);
        case (m)
            2'd0:    up = (rem > half) || ((rem == half) && q[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = nx && s;
            default: up = nx && !s;
        endcase
        q = q + 64'(up);
        if (q == 64'd16777216) begin
            q = q >> 1;
            eb++;
        end
        if (eb >= 255) begin
            inf_v = {s, 8'hFF, 23'd0};
            max_v = {s, 8'hFE, 23'h7FFFFF};
            case (m)
                2'd0:    r = inf_v;
                2'd1:    r = max_v;
                2'd2:    r = s ? inf_v : max_v;
                default: r = s ? max_v : inf_v;
            endcase
            return {r, 4'b0101};
        end
        return {s, 8'(eb), q[22:0], 3'b000, nx};
    endfunction

    function automatic logic [31:0] rand_op();
        logic       s;
        logic [7:0] e;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        e = 8'($urandom_range(100, 154));
        case ($urandom_range(0, 9))
            0, 1:    return $urandom;
            5:       e = 8'($urandom_range(190, 254));
            6:       e = 8'($urandom_range(1, 70));
            7: begin
                e = 8'h00;
                if ($urandom_range(0, 1) == 0) f = 23'd0;
            end
            8: begin
                e = 8'hFF;
                case ($urandom_range(0, 2))
                    0:       f = 23'd0;
                    1:       f = {1'b1, 22'($urandom)};
                    default: f = {1'b0, 22'($urandom_range(1, 4194303))};
                endcase
            end
            9: begin
                e = 8'd127;
                f = 23'($urandom_range(0, 3));
            end
            default: ;
        endcase
        return {s, e, f};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input logic [4:0] t, input logic [35:0] e, input bit lat);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        rm = m;
        in_tag = t;
        #2;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted tag=%0d", t);
        end else begin
            exp_q.push_back({e, t});
            acc_q.push_back(cyc);
            lat_q.push_back(lat);
        end
        @(posedge clk);
    endtask

    task automatic send_rand(input logic [4:0] t);
        logic [31:0] a, b;
        logic [1:0]  m;
        a = rand_op();
        b = rand_op();
        m = 2'($urandom_range(0, 3));
        send(a, b, m, t, ref_mul(a, b, m), 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] held, cur, e;
        bit held_v;
        int acc;
        bit lat;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                held_v = 1'b0;
            end else if (out_valid) begin
                cur = {y, flags, out_tag};
                if (held_v) check("stall_stable", 64'(cur), 64'(held));
                if (out_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%h required=none", cur);
                    end else begin
                        e   = exp_q.pop_front();
                        acc = acc_q.pop_front();
                        lat = lat_q.pop_front();
                        check("y", 64'(y), 64'(e[EW-1 -: W]));
                        check("flags", 64'(flags), 64'(e[TAG_W+3 -: 4]));
                        check("tag", 64'(out_tag), 64'(e[TAG_W-1:0]));
                        if (lat) check("latency", 64'(cyc - acc), 64'd3);
                    end
                end else begin
                    held_v = 1'b1;
                    held   = cur;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        x1 = '0;
        x2 = '0;
        rm = 2'd0;
        in_tag = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;

        // directed vectors with hand-derived results
        send(32'h3FC00000, 32'h40000000, 2'd0, 5'd7,  {32'h40400000, 4'b0000}, 1'b1);
        send(32'h3F800001, 32'h3FC00000, 2'd0, 5'd1,  {32'h3FC00002, 4'b0001}, 1'b0);
        send(32'h3F800001, 32'h3FC00000, 2'd1, 5'd2,  {32'h3FC00001, 4'b0001}, 1'b0);
        send(32'h3F800001, 32'h3FC00000, 2'd3, 5'd3,  {32'h3FC00002, 4'b0001}, 1'b0);
        send(32'h3F800001, 32'h3FC00000, 2'd2, 5'd4,  {32'h3FC00001, 4'b0001}, 1'b0);
        send(32'h7F000000, 32'h40000000, 2'd0, 5'd5,  {32'h7F800000, 4'b0101}, 1'b0);
        send(32'h7F000000, 32'h40000000, 2'd1, 5'd6,  {32'h7F7FFFFF, 4'b0101}, 1'b0);
        send(32'hFF000000, 32'h40000000, 2'd3, 5'd8,  {32'hFF7FFFFF, 4'b0101}, 1'b0);
        send(32'hFF000000, 32'h40000000, 2'd2, 5'd9,  {32'hFF800000, 4'b0101}, 1'b0);
        send(32'h7F000000, 32'h40000000, 2'd3, 5'd10, {32'h7F800000, 4'b0101}, 1'b0);
        send(32'h7F800000, 32'h00000000, 2'd0, 5'd11, {32'h7FC00000, 4'b1000}, 1'b0);
        send(32'h7F800001, 32'h3F800000, 2'd0, 5'd12, {32'h7FC00000, 4'b1000}, 1'b0);
        send(32'h80800000, 32'h3F000000, 2'd0, 5'd13, {32'h80000000, 4'b0011}, 1'b0);
        send(32'h7FC00001, 32'h3F800000, 2'd0, 5'd14, {32'h7FC00000, 4'b0000}, 1'b0);
        send(32'h7F800000, 32'hC0000000, 2'd0, 5'd15, {32'hFF800000, 4'b0000}, 1'b0);
        send(32'h00000001, 32'h3F800000, 2'd0, 5'd16, {32'h00000000, 4'b0000}, 1'b0);
        send(32'h80000000, 32'h40A00000, 2'd0, 5'd17, {32'h80000000, 4'b0000}, 1'b0);
        idle(2);
        drain();

        // backpressure: four back-to-back ops behind a held output
        #1;
        ready_mode = 1;
        fork
            begin
                for (int t = 1; t <= 4; t++) send_rand(5'(t));
                idle(1);
            end
            begin
                repeat (6) @(negedge clk);
                #3;
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_head_tag", 64'(out_tag), 64'd1);
                ready_mode = 0;
            end
        join
        drain();

        // randomized traffic with random output backpressure and input gaps
        #1;
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send_rand(5'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        drain();

        // reset with three ops in flight
        #1;
        ready_mode = 1;
        for (int t = 20; t < 23; t++) send_rand(5'(t));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_y", 64'(y), 64'd0);
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        ready_mode = 0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #2;
            check("rst_no_ghost", 64'(out_valid), 64'd0);
        end
        send(32'h40400000, 32'h40400000, 2'd0, 5'd30, {32'h41100000, 4'b0000}, 1'b1);
        idle(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
